sort_ram_ctrl: RTL and testbench
================================

# sort_ram_ctrl

Controller that owns both ports of a dual-port synchronous RAM (ram_2port) holding an array of unsigned words. It arbitrates RAM access between a host load/readback port and an internal bubble-sort sequencer with early exit on a pass with no swaps. The host loads data, pulses `start`, waits for `done`, then reads back the sorted array.

## Interface
- `AW`, 8: RAM address width.
- `DW`, 8: data word width.
- `CW`, 16: `swap_count` width.

- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sort request. Sampled only in IDLE.
- `len`  in  AW  element count, latched on `start` acceptance.
- `busy`  out  1  high from `start` acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse at sort completion.
- `swap_count`  out  CW  swaps performed by the last sort. Saturates at all-ones.
- `host_req`, `host_we`  in  1  host access request and write enable.
- `host_addr`  in  AW;  `host_wdata`  in  DW.
- `host_gnt`  out  1  access accepted this cycle.
- `host_rvalid`  out  1  read data valid, one cycle after a granted read.
- `host_rdata`  out  DW  equals `q_a` when `host_rvalid` is high.
- `address_a`, `address_b`  out  AW;  `data_a`, `data_b`  out  DW;  `wren_a`, `wren_b`  out  1  RAM ports.
- `q_a`, `q_b`  in  DW  RAM read data, valid 1 cycle after the address is presented.

## Operation
- Reset: state IDLE. All outputs 0: addresses, data, wren, busy, done, gnt, rvalid, swap_count.
- FSM states: IDLE, READ, COMPARE, WRITE, ADVANCE, DONE.
- IDLE, `start`=1 (start has priority over `host_req`; `host_gnt`=0 that cycle):
  - latch `bound`=`len`-1, `j`=0, `swapped`=0, `swap_count`=0.
  - `len`<2 → DONE; otherwise → READ.
- IDLE, `start`=0, `host_req`=1:
  - `host_gnt`=1 combinationally. Port A is driven with `host_addr`/`host_wdata`, and `wren_a`=`host_we`.
  - Port B is idle, with `wren_b`=0.
  - Granted read → `host_rvalid`=1 next cycle.
- READ: `address_a`=`j`, `address_b`=`j`+1, wren=0 → COMPARE.
- COMPARE: register `q_a`,`q_b`, then compare unsigned.
  - `q_a`>`q_b` → WRITE.
  - otherwise (including equal values) → ADVANCE.
- WRITE: addresses held. `data_a`=registered `q_b`, `data_b`=registered `q_a`, `wren_a`=`wren_b`=1 for exactly this cycle. Set `swapped`=1 and increment `swap_count` (saturating). → ADVANCE.
- ADVANCE:
  - `j`+1≠`bound` → `j`++, go to READ.
  - `j`+1=`bound` (end of pass):
    - `swapped`=0 or `bound`=1 → DONE.
    - otherwise `bound`--, `j`=0, `swapped`=0, go to READ.
- DONE: `done`=1, `busy`=1 → IDLE. From the next cycle `busy`=0; `swap_count` holds until the next accepted `start`.
- During sort: `host_gnt`=0 and `start` is ignored. Host must hold `host_req` until granted.
- Address arithmetic: `j`+1 never exceeds `len`-1, so there is no wrap.
- Reset mid-sort: return to IDLE immediately. A swap is atomic because both ports are written in one cycle, so the RAM always holds a permutation of the loaded data.

## Timing
- `start` sampled at edge 0; READ is cycle 1.
- Per comparison: 3 cycles without a swap, 4 with a swap.
- `len`<2: `done` high in cycle 1.
- Sorted input of length n: `done` high in cycle 3(n-1)+1.
- Host write: 1 cycle. Host read: data valid 1 cycle after grant. Back-to-back host accesses are allowed each cycle.
- `done` never asserts in the same cycle as `host_gnt`.

## Test plan
- Load [5,3,9,1], `len`=4, pulse `start` → RAM reads back [1,3,5,9], `swap_count`=4, `done` is a single pulse.
- Load [1,2,3,4], `len`=4 → `done` in cycle 10 after start, `swap_count`=0, no `wren` pulses.
- Load [8,7,6,5,4,3,2,1], `len`=8 → [1..8], `swap_count`=28. `busy` is high continuously until the cycle after `done`.
- `len`=1, then `len`=0 → `done` in cycle 1, `swap_count`=0, RAM unchanged. Load [7,7,2], `len`=3 → [2,7,7], `swap_count`=2.
- `host_req` read asserted during a sort → `host_gnt`=0 until IDLE. Then grant, with correct `host_rdata` one cycle later. `start` and `host_req` in the same IDLE cycle → start wins.
- `reset_n` low mid-sort, during a WRITE cycle → outputs 0 at once, FSM in IDLE. Readback is a permutation of the loaded data, and a new sort completes correctly.

Source files
------------

// File: rtl/sort_ram_ctrl_if.sv
// Bundles the host access port, sort control/status and both RAM ports of sort_ram_ctrl.
// The controller connects to the slave modport; the host/RAM side connects to the master modport.
interface sort_ram_ctrl_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8,
   parameter int unsigned CW = 16
);
   logic          start;
   logic [AW-1:0] len;
   logic          busy;
   logic          done;
   logic [CW-1:0] swap_count;

   logic          host_req;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_gnt;
   logic          host_rvalid;
   logic [DW-1:0] host_rdata;

   logic [AW-1:0] address_a;
   logic [AW-1:0] address_b;
   logic [DW-1:0] data_a;
   logic [DW-1:0] data_b;
   logic          wren_a;
   logic          wren_b;
   logic [DW-1:0] q_a;
   logic [DW-1:0] q_b;

   modport master (
      output start, len, host_req, host_we, host_addr, host_wdata, q_a, q_b,
      input  busy, done, swap_count, host_gnt, host_rvalid, host_rdata,
             address_a, address_b, data_a, data_b, wren_a, wren_b
   );

   modport slave (
      input  start, len, host_req, host_we, host_addr, host_wdata, q_a, q_b,
      output busy, done, swap_count, host_gnt, host_rvalid, host_rdata,
             address_a, address_b, data_a, data_b, wren_a, wren_b
   );
endinterface

// File: rtl/sort_ram_ctrl.sv
// Dual-port RAM controller: host load/readback in IDLE, otherwise an in-place bubble sort
// with early exit on a pass that performs no swaps.
module sort_ram_ctrl #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8,
   parameter int unsigned CW = 16
) (
   input logic             clock,
   input logic             reset_n,
   sort_ram_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_COMPARE,
      S_WRITE,
      S_ADVANCE,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_nx;

   logic [AW-1:0] j;
   logic [AW-1:0] bound;
   logic          swapped;
   logic [CW-1:0] swap_count;
   logic [DW-1:0] qa_r;
   logic [DW-1:0] qb_r;
   logic          busy;
   logic          done;
   logic          rvalid;

   logic          accept_c;
   logic          grant_c;
   logic          last_pair_c;
   logic [AW-1:0] addr_a_c;
   logic [AW-1:0] addr_b_c;
   logic [DW-1:0] data_a_c;
   logic [DW-1:0] data_b_c;
   logic          wren_a_c;
   logic          wren_b_c;

   assign accept_c    = (state == S_IDLE) && bus.start;
   assign grant_c     = (state == S_IDLE) && !bus.start && bus.host_req;
   assign last_pair_c = ((j + AW'(1)) == bound);

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // Next state and RAM port drive; the host owns port A only while granted in IDLE
   always_comb begin
      state_nx = state;
      addr_a_c = '0;
      addr_b_c = '0;
      data_a_c = '0;
      data_b_c = '0;
      wren_a_c = 1'b0;
      wren_b_c = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_nx = (bus.len < AW'(2)) ? S_DONE : S_READ;
            end else if (bus.host_req) begin
               addr_a_c = bus.host_addr;
               data_a_c = bus.host_wdata;
               wren_a_c = bus.host_we;
            end
         end
         S_READ: begin
            addr_a_c = j;
            addr_b_c = j + AW'(1);
            state_nx = S_COMPARE;
         end
         S_COMPARE: begin
            addr_a_c = j;
            addr_b_c = j + AW'(1);
            state_nx = (bus.q_a > bus.q_b) ? S_WRITE : S_ADVANCE;
         end
         S_WRITE: begin
            addr_a_c = j;
            addr_b_c = j + AW'(1);
            data_a_c = qb_r;
            data_b_c = qa_r;
            wren_a_c = 1'b1;
            wren_b_c = 1'b1;
            state_nx = S_ADVANCE;
         end
         S_ADVANCE: begin
            addr_a_c = j;
            addr_b_c = j + AW'(1);
            if (!last_pair_c)                         state_nx = S_READ;
            else if (!swapped || (bound == AW'(1)))   state_nx = S_DONE;
            else                                      state_nx = S_READ;
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Sort bookkeeping, captured pair and registered status
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         j          <= '0;
         bound      <= '0;
         swapped    <= 1'b0;
         swap_count <= '0;
         qa_r       <= '0;
         qb_r       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rvalid     <= 1'b0;
      end else begin
         busy   <= (state_nx != S_IDLE);
         done   <= (state_nx == S_DONE);
         rvalid <= grant_c && !bus.host_we;
         if (accept_c) begin
            bound      <= bus.len - AW'(1);
            j          <= '0;
            swapped    <= 1'b0;
            swap_count <= '0;
         end
         if (state == S_COMPARE) begin
            qa_r <= bus.q_a;
            qb_r <= bus.q_b;
         end
         if (state == S_WRITE) begin
            swapped <= 1'b1;
            if (swap_count != {CW{1'b1}}) swap_count <= swap_count + CW'(1);
         end
         if (state == S_ADVANCE) begin
            if (!last_pair_c) begin
               j <= j + AW'(1);
            end else if (swapped && (bound != AW'(1))) begin
               bound   <= bound - AW'(1);
               j       <= '0;
               swapped <= 1'b0;
            end
         end
      end
   end

   assign bus.address_a   = addr_a_c;
   assign bus.address_b   = addr_b_c;
   assign bus.data_a      = data_a_c;
   assign bus.data_b      = data_b_c;
   assign bus.wren_a      = wren_a_c;
   assign bus.wren_b      = wren_b_c;
   assign bus.host_gnt    = grant_c;
   assign bus.host_rvalid = rvalid;
   assign bus.host_rdata  = rvalid ? bus.q_a : '0;
   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.swap_count  = swap_count;

endmodule

// File: tb/tb_sort_ram_ctrl.sv
// Randomized bench for sort_ram_ctrl: behavioural dual-port RAM, host load/readback,
// and a reference model giving sorted contents, swap count (inversions) and done latency.
module tb_sort_ram_ctrl;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 16;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   sort_ram_ctrl_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

   sort_ram_ctrl #(.AW(AW), .DW(DW), .CW(CW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   // Behavioural ram_2port: synchronous read, old data on read-during-write
   logic [DW-1:0] mem [256] = '{default: '0};
   always_ff @(posedge clock) begin
      if (bus.wren_a) mem[bus.address_a] <= bus.data_a;
      if (bus.wren_b) mem[bus.address_b] <= bus.data_b;
      bus.q_a <= mem[bus.address_a];
      bus.q_b <= mem[bus.address_b];
   end

   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] shadow [256] = '{default: '0};
   int            vals [$];
   int            last_cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clock);
      bus.host_req   = 1'b1;
      bus.host_we    = 1'b1;
      bus.host_addr  = a;
      bus.host_wdata = d;
      #1 check("wr_gnt", 32'(bus.host_gnt), 32'd1);
      @(posedge clock);
      #1 bus.host_req = 1'b0;
      bus.host_we = 1'b0;
   endtask

   task automatic host_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
      @(negedge clock);
      bus.host_req  = 1'b1;
      bus.host_we   = 1'b0;
      bus.host_addr = a;
      #1 check("rd_gnt", 32'(bus.host_gnt), 32'd1);
      @(posedge clock);
      #1 bus.host_req = 1'b0;
      @(negedge clock);
      check("rd_valid", 32'(bus.host_rvalid), 32'd1);
      d = bus.host_rdata;
   endtask

   task automatic load_vals();
      for (int i = 0; i < vals.size(); i++) begin
         shadow[i] = DW'(vals[i]);
         host_write(AW'(i), DW'(vals[i]));
      end
   endtask

   task automatic load_random(input int n, input int maxv);
      vals = {};
      for (int i = 0; i < n; i++) vals.push_back(int'($urandom_range(0, maxv)));
      load_vals();
   endtask

   task automatic readback(input int n);
      logic [DW-1:0] d;
      int            lim;
      lim = (n + 2 > 256) ? 256 : n + 2;
      for (int i = 0; i < lim; i++) begin
         host_read(AW'(i), d);
         check($sformatf("ram[%0d]", i), 32'(d), 32'(shadow[i]));
      end
   endtask

   // Reference: sorted contents, swaps = inversion count, latency = 3/4 cycles per comparison
   task automatic do_sort(input int n, input bit with_host);
      int a [$];
      int s [$];
      int exp_sw, exp_cyc, bnd, t, cyc, wr_pulses, busy_drop, gnt_seen;
      bit sw;
      a = {};
      for (int i = 0; i < n; i++) a.push_back(int'(shadow[i]));
      s = a;
      s.sort();
      exp_sw = 0;
      for (int i = 0; i < n; i++)
         for (int k = i + 1; k < n; k++)
            if (a[i] > a[k]) exp_sw++;
      exp_cyc = 1;
      if (n >= 2) begin
         bnd = n - 1;
         forever begin
            sw = 1'b0;
            for (int k = 0; k < bnd; k++) begin
               exp_cyc += 3;
               if (a[k] > a[k+1]) begin
                  t = a[k]; a[k] = a[k+1]; a[k+1] = t;
                  exp_cyc += 1;
                  sw = 1'b1;
               end
            end
            if (!sw || bnd == 1) break;
            bnd--;
         end
      end

      @(negedge clock);
      bus.start = 1'b1;
      bus.len   = AW'(n);
      if (with_host) begin
         bus.host_req  = 1'b1;
         bus.host_we   = 1'b0;
         bus.host_addr = '0;
         #1 check("start_beats_req", 32'(bus.host_gnt), 32'd0);
      end
      @(posedge clock);
      #1 bus.start = 1'b0;

      cyc = 0; wr_pulses = 0; busy_drop = 0; gnt_seen = 0;
      for (int c = 1; c <= 5000; c++) begin
         @(negedge clock);
         if (!bus.busy)   busy_drop++;
         if (bus.wren_a)  wr_pulses++;
         if (bus.host_gnt) gnt_seen++;
         if (bus.done) begin
            cyc = c;
            break;
         end
      end
      last_cyc = cyc;
      check("done_cycle", 32'(cyc), 32'(exp_cyc));
      check("busy_gap", 32'(busy_drop), 32'd0);
      check("wren_pulses", 32'(wr_pulses), 32'(exp_sw));
      check("swap_count", 32'(bus.swap_count), 32'(exp_sw));
      if (with_host) check("gnt_during_sort", 32'(gnt_seen), 32'd0);

      @(negedge clock);
      check("done_pulse", 32'(bus.done), 32'd0);
      check("busy_after", 32'(bus.busy), 32'd0);
      for (int i = 0; i < n; i++) shadow[i] = DW'(s[i]);
      if (with_host) begin
         check("gnt_in_idle", 32'(bus.host_gnt), 32'd1);
         @(posedge clock);
         #1 bus.host_req = 1'b0;
         @(negedge clock);
         check("held_rvalid", 32'(bus.host_rvalid), 32'd1);
         check("held_rdata", 32'(bus.host_rdata), 32'(shadow[0]));
      end
      readback(n);
   endtask

   task automatic reset_mid_write();
      int            orig [$];
      int            got [$];
      logic [DW-1:0] d;
      int            found;
      vals = {9, 8, 3, 12, 1, 7, 0, 5, 10, 2};
      load_vals();
      orig = vals;
      orig.sort();
      @(negedge clock);
      bus.start = 1'b1;
      bus.len   = AW'(10);
      @(posedge clock);
      #1 bus.start = 1'b0;
      found = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         if (bus.wren_a && bus.wren_b && c > 6) begin
            found = 1;
            break;
         end
      end
      check("reach_write", 32'(found), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst_status", {29'd0, bus.busy, bus.done, bus.host_rvalid}, 32'd0);
      check("rst_wren", {30'd0, bus.wren_a, bus.wren_b}, 32'd0);
      check("rst_addr", {16'd0, bus.address_a, bus.address_b}, 32'd0);
      check("rst_data", {16'd0, bus.data_a, bus.data_b}, 32'd0);
      check("rst_swaps", 32'(bus.swap_count), 32'd0);
      check("rst_gnt", 32'(bus.host_gnt), 32'd0);
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      got = {};
      for (int i = 0; i < 10; i++) begin
         host_read(AW'(i), d);
         got.push_back(int'(d));
      end
      got.sort();
      for (int i = 0; i < 10; i++) check($sformatf("perm[%0d]", i), 32'(got[i]), 32'(orig[i]));
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.len        = '0;
      bus.host_req   = 1'b0;
      bus.host_we    = 1'b0;
      bus.host_addr  = '0;
      bus.host_wdata = '0;
      reset_n        = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_status", {29'd0, bus.busy, bus.done, bus.host_rvalid}, 32'd0);
      check("reset_ports", {bus.address_a, bus.address_b, bus.data_a, bus.data_b}, 32'd0);
      check("reset_wren_gnt", {29'd0, bus.wren_a, bus.wren_b, bus.host_gnt}, 32'd0);
      check("reset_swaps", 32'(bus.swap_count), 32'd0);
      reset_n = 1'b1;

      vals = {5, 3, 9, 1};
      load_vals();
      do_sort(4, 1'b0);
      check("swaps_5391", 32'(bus.swap_count), 32'd4);

      vals = {1, 2, 3, 4};
      load_vals();
      do_sort(4, 1'b0);
      check("sorted4_cycle", 32'(last_cyc), 32'd10);

      vals = {8, 7, 6, 5, 4, 3, 2, 1};
      load_vals();
      do_sort(8, 1'b0);
      check("swaps_rev8", 32'(bus.swap_count), 32'd28);

      do_sort(1, 1'b0);
      check("len1_cycle", 32'(last_cyc), 32'd1);
      do_sort(0, 1'b0);
      check("len0_cycle", 32'(last_cyc), 32'd1);

      vals = {7, 7, 2};
      load_vals();
      do_sort(3, 1'b0);
      check("swaps_772", 32'(bus.swap_count), 32'd2);

      load_random(6, 255);
      do_sort(6, 1'b1);

      for (int it = 0; it < 10; it++) begin
         int n;
         n = int'($urandom_range(0, 24));
         load_random(n, (it % 2 == 0) ? 15 : 255);
         do_sort(n, (it % 3 == 0));
      end

      reset_mid_write();
      load_random(12, 31);
      do_sort(12, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
